apb_xfer_ctrl: RTL
==================

APB_XFER_CTRL -- requirements
Module: apb_xfer_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, AHB/APB address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum ACCESS wait cycles; 0 disables the timeout.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- hclk, in, 1, sole clock; all state changes on its rising edge.
- hresetn, in, 1, asynchronous active-low reset.
- hsel, in, 1, bridge selected.
- htrans, in, 2, AHB transfer type.
- hwrite, in, 1, AHB direction.
- haddr, in, ADDR_W, AHB address.
- hwdata, in, DATA_W, AHB write data (data phase).
- hready_in, in, 1, AHB bus ready.
- hready_out, out, 1, bridge ready to AHB.
- hresp, out, 1, 0 = OKAY, 1 = ERROR.
- hrdata, out, DATA_W, read data to AHB.
- psel_en, out, 1, enable for the slave-select gating stage.
- penable, out, 1, APB enable.
- pwrite, out, 1, APB direction.
- paddr, out, ADDR_W, APB address.
- pwdata, out, DATA_W, APB write data.
- prdata, in, DATA_W, APB read data.
- pready, in, 1, APB ready.
- pslverr, in, 1, APB slave error.

Function
REQ-003 Valid transfer SHALL be hsel & htrans[1] & hready_in; IDLE (00) and BUSY (01) SHALL be ignored.
REQ-004 FSM states SHALL be IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
REQ-005 IDLE/ERR2 with valid transfer SHALL capture haddr->paddr and hwrite->pwrite, then go to LATCH; without one, go to (stay in) IDLE.
REQ-006 LATCH SHALL capture hwdata->pwdata (reads included), drive hready_out=0, then go to SETUP.
REQ-007 SETUP SHALL drive psel_en=1, penable=0, hready_out=0, clear the wait counter, then go to ACCESS.
REQ-008 ACCESS SHALL drive psel_en=1, penable=1, hready_out=0; paddr, pwrite and pwdata SHALL stay stable from SETUP through the end of ACCESS.
REQ-009 ACCESS with pready=1 and pslverr=0 SHALL register prdata->hrdata (reads only) and go to IDLE; hready_out=1, hresp=0 in that IDLE cycle.
REQ-010 ACCESS with pready=1 and pslverr=1 SHALL go to ERR1; hrdata SHALL remain unchanged.
REQ-011 ACCESS with pready=0 SHALL increment the wait counter. When TIMEOUT>0 and the counter equals TIMEOUT, the FSM SHALL go to ERR1 and deassert psel_en/penable that edge.
REQ-012 ERR1 SHALL drive hready_out=0, hresp=1, psel_en=0. ERR2 SHALL drive hready_out=1, hresp=1.
REQ-013 hready_out SHALL be 1 only in IDLE and ERR2, 0 in all other states. hresp SHALL be 1 only in ERR1/ERR2.
REQ-014 Minimum transfer latency SHALL be 4 cycles: address phase (IDLE), LATCH, SETUP, ACCESS, completing in the following IDLE cycle with zero APB wait states.
REQ-015 Back-to-back transfers SHALL be accepted in the completion cycle (IDLE/ERR2), with no extra idle cycle.
REQ-016 The wait counter SHALL be $clog2(TIMEOUT+1) bits (min 1) and SHALL saturate rather than wrap.

Reset
REQ-017 hresetn low SHALL immediately force IDLE, with hready_out=1, hresp=0, psel_en=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, counter=0, including mid-transfer.
REQ-018 After deassertion, the first valid transfer SHALL be sampled on the first rising edge with hresetn high.

Structure
REQ-019 State encodings and the HRESP OKAY/ERROR constants SHALL reside in the shared bridge package; `NUM_APB_SLAVES remains in the global defines.
REQ-020 The wait counter and timeout compare SHALL be the sub-module apb_wait_timer (inputs clear/inc, output expired).
REQ-021 Only registered FSM and datapath logic is permitted; no latches.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write haddr=0x40, hwdata=0xA5A5_0001, pready=1: psel_en high 2 cycles, penable 1 cycle, pwdata=0xA5A5_0001, hready_out low 3 cycles, hresp=0.
- Read with pready low for 3 ACCESS cycles, prdata=0x1234_5678: ACCESS lasts 4 cycles, hrdata=0x1234_5678 with hready_out=1.
- pslverr=1 with pready: hready_out sequence 0 (ERR1), 1 (ERR2) with hresp=1 both cycles, then IDLE.
- TIMEOUT=4, pready held 0: ERR1 entered after 4 wait cycles, psel_en=0, two-cycle error response.
- Back-to-back write/read with a new address issued in the completion cycle: second SETUP follows its LATCH with no gap; BUSY transfer ignored.
- hresetn asserted during ACCESS: all outputs at reset values asynchronously; next transfer completes normally.

Source files
------------

// File: rtl/apb_xfer_ctrl_pkg.sv
// Shared definitions for the AHB-to-APB transfer controller: FSM state encoding,
// AHB response codes and AHB transfer-type decoding.
package apb_xfer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } xfer_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;

    // NONSEQ and SEQ start a transfer; IDLE and BUSY never do.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB ACCESS phase with a timeout flag;
// TIMEOUT = 0 disables the flag.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Fires on the wait cycle whose increment brings the count to TIMEOUT, so the
    // FSM leaves ACCESS on the same edge the counter reaches the limit.
    assign expired = (TIMEOUT > 0) && inc && (count_q == CNT_LAST);

endmodule

// File: rtl/apb_xfer_ctrl.sv
// AHB-to-APB transfer controller: turns one AHB transfer at a time into an APB
// SETUP/ACCESS sequence and returns the APB outcome as an AHB response.
module apb_xfer_ctrl
    import apb_xfer_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready_in,
    output logic              hready_out,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              psel_en,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    xfer_state_t state_q;
    xfer_state_t state_d;
    logic        xfer_valid;
    logic        accept;
    logic        timer_clear;
    logic        timer_inc;
    logic        timer_expired;

    assign xfer_valid = hsel && htrans_active(htrans) && hready_in;
    assign accept     = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) && xfer_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always_ff blocks run in.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output is given a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: state_d = xfer_valid ? ST_LATCH : ST_IDLE;
            ST_LATCH:         state_d = ST_SETUP;
            ST_SETUP: begin
                timer_clear = 1'b1;
                state_d     = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_d = pslverr ? ST_ERR1 : ST_IDLE;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_ERR1;
                    end
                end
            end
            ST_ERR1:          state_d = ST_ERR2;
            default:          state_d = ST_IDLE;
        endcase
    end

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .hclk    (hclk),
        .hresetn (hresetn),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // Address and direction come from the AHB address phase, write data one cycle
    // later from the data phase; all hold until the next accepted transfer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
        end else begin
            if (accept) begin
                paddr  <= haddr;
                pwrite <= hwrite;
            end
            if (state_q == ST_LATCH) begin
                pwdata <= hwdata;
            end
            if ((state_q == ST_ACCESS) && pready && !pslverr && !pwrite) begin
                hrdata <= prdata;
            end
        end
    end

    assign hready_out = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign psel_en    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable    = (state_q == ST_ACCESS);

endmodule
